// File: rtl/row_block_builder_pkg.sv
// Shared types and sizing helpers for the row block builder
// (FSM state encoding and a width function safe for tiny dimensions).
package row_block_builder_pkg;

  typedef enum logic {
    ACCEPT = 1'b0,
    COMMIT = 1'b1
  } state_t;

  // $clog2 returns 0 for 1, which would give zero-width counters.
  function automatic int bits_for(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/row_block_builder_if.sv
// Pixel-stream input and row-block output handshakes of the row block builder.
// master = producer of pixels / consumer of blocks, slave = the builder itself.
interface row_block_builder_if #(
  parameter int WIN       = 15,
  parameter int DATA_SIZE = 8,
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480
);
  import row_block_builder_pkg::*;

  localparam int BLOCK_W = DATA_SIZE * IMG_W * WIN;
  localparam int ROW_W   = bits_for(IMG_H);

  logic [DATA_SIZE-1:0] pix_data;
  logic                 pix_valid;
  logic                 pix_sof;
  logic                 pix_ready;

  logic [BLOCK_W-1:0]   block_data;
  logic                 block_valid;
  logic                 block_ready;
  logic [ROW_W-1:0]     block_row;
  logic                 block_last;

  modport master (
    output pix_data, pix_valid, pix_sof, block_ready,
    input  pix_ready, block_data, block_valid, block_row, block_last
  );

  modport slave (
    input  pix_data, pix_valid, pix_sof, block_ready,
    output pix_ready, block_data, block_valid, block_row, block_last
  );

endinterface

// File: rtl/row_block_builder_window_row_store.sv
// Line buffer for the row being received plus WIN rows of window storage.
// Row 0 (oldest) sits in the LSBs; a shift drops it and appends the line buffer on top.
module row_block_builder_window_row_store
  import row_block_builder_pkg::*;
#(
  parameter int WIN       = 15,
  parameter int DATA_SIZE = 8,
  parameter int IMG_W     = 640
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [bits_for(IMG_W)-1:0]     wr_col,
  input  logic [DATA_SIZE-1:0]           wr_data,
  input  logic                           shift,
  output logic [DATA_SIZE*IMG_W*WIN-1:0] block_data
);

  localparam int ROW_BITS = DATA_SIZE * IMG_W;
  localparam int BLOCK_W  = ROW_BITS * WIN;

  logic [ROW_BITS-1:0] line_q;
  logic [BLOCK_W-1:0]  window_q;
  logic [BLOCK_W-1:0]  line_ext;
  logic [BLOCK_W-1:0]  shifted;

  // Zero-extend before shifting so WIN=1 needs no special case.
  always_comb begin
    line_ext                 = '0;
    line_ext[ROW_BITS-1:0]   = line_q;
    shifted = (window_q >> ROW_BITS) | (line_ext << (BLOCK_W - ROW_BITS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q   <= '0;
      window_q <= '0;
    end else begin
      if (wr_en) begin
        line_q[wr_col*DATA_SIZE +: DATA_SIZE] <= wr_data;
      end
      if (shift) begin
        window_q <= shifted;
      end
    end
  end

  assign block_data = window_q;

endmodule

// File: rtl/row_block_builder.sv
// Collects a raster pixel stream into the last WIN rows and presents one flattened
// WIN x IMG_W block per completed row once the window is full.
module row_block_builder
  import row_block_builder_pkg::*;
#(
  parameter int WIN       = 15,
  parameter int DATA_SIZE = 8,
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480
) (
  input  logic               clk,
  input  logic               rst,
  row_block_builder_if.slave bus
);

  localparam int HALF_WIN = WIN >> 1;
  localparam int COL_W    = bits_for(IMG_W);
  localparam int ROW_W    = bits_for(IMG_H);
  localparam int LOADED_W = bits_for(WIN + 1);

  state_t              state;
  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;
  logic [LOADED_W-1:0] rows_loaded;
  logic                block_valid_q;
  logic [ROW_W-1:0]    block_row_q;
  logic                block_last_q;

  logic                accept;
  logic                fire;
  logic [COL_W-1:0]    wr_col;
  logic [LOADED_W-1:0] loaded_inc;

  assign bus.pix_ready = (state == ACCEPT) && !rst;
  assign accept        = bus.pix_valid && bus.pix_ready;
  assign fire          = (state == COMMIT) && (!block_valid_q || bus.block_ready);
  assign wr_col        = bus.pix_sof ? '0 : col;
  assign loaded_inc    = (rows_loaded == LOADED_W'(WIN)) ? rows_loaded
                                                         : rows_loaded + 1'b1;

  // A commit that fires while the current block is being taken overrides the
  // plain valid drop below, giving back-to-back blocks with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ACCEPT;
      col           <= '0;
      row           <= '0;
      rows_loaded   <= '0;
      block_valid_q <= 1'b0;
      block_row_q   <= '0;
      block_last_q  <= 1'b0;
    end else begin
      if (block_valid_q && bus.block_ready) begin
        block_valid_q <= 1'b0;
      end
      case (state)
        ACCEPT: begin
          if (accept) begin
            if (bus.pix_sof) begin
              row         <= '0;
              rows_loaded <= '0;
            end
            if (wr_col == COL_W'(IMG_W - 1)) begin
              col   <= '0;
              state <= COMMIT;
            end else begin
              col <= wr_col + 1'b1;
            end
          end
        end
        COMMIT: begin
          if (fire) begin
            rows_loaded <= loaded_inc;
            if (loaded_inc == LOADED_W'(WIN)) begin
              block_valid_q <= 1'b1;
              block_row_q   <= row - ROW_W'(HALF_WIN);
              block_last_q  <= (row == ROW_W'(IMG_H - 1));
            end else begin
              block_valid_q <= 1'b0;
            end
            // The window keeps stale rows across frames; rows_loaded gates reuse.
            if (row == ROW_W'(IMG_H - 1)) begin
              row         <= '0;
              rows_loaded <= '0;
            end else begin
              row <= row + 1'b1;
            end
            state <= ACCEPT;
          end
        end
        default: state <= ACCEPT;
      endcase
    end
  end

  row_block_builder_window_row_store #(
    .WIN       (WIN),
    .DATA_SIZE (DATA_SIZE),
    .IMG_W     (IMG_W)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (accept),
    .wr_col     (wr_col),
    .wr_data    (bus.pix_data),
    .shift      (fire),
    .block_data (bus.block_data)
  );

  assign bus.block_valid = block_valid_q;
  assign bus.block_row   = block_row_q;
  assign bus.block_last  = block_last_q;

endmodule
